// File: rtl/poly_fifo_reader.sv
// rtl/poly_fifo_reader.sv - iNTT polynomial FIFO drain stage: two-line RAM reads to a line stream (optional counters: POLY_FIFO_READER_PERF_EN)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 2
`endif

module poly_fifo_reader #(
  parameter int POLY_LINES = 2**`ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               sink_empty,
  input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]   sink_dA,
  input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]   sink_dB,
  output logic [`ADDR_WIDTH-1:0]             sink_addrA,
  output logic [`ADDR_WIDTH-1:0]             sink_addrB,
  output logic                               rd_finish,
  output logic                               rd_en,
  output logic [`BIT_WIDTH*`LINE_SIZE-1:0]   out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last
`ifdef POLY_FIFO_READER_PERF_EN
  ,
  output logic [15:0]                        poly_cnt,
  output logic [31:0]                        stall_cnt
`endif
);

  localparam int AW = `ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE, BEAT_A, BEAT_B, FINISH} state_t;

  state_t        state;
  logic [AW-1:0] k;
  logic [AW-1:0] pair;
  logic          last_pair;
  logic          adv;

  assign last_pair = (k == AW'(POLY_LINES/2 - 1));
  // Accepting a non-final B line immediately fetches the next pair so A data lands on the next cycle.
  assign adv       = (state == BEAT_B) && out_ready && !last_pair;
  assign rd_en     = (state == ISSUE) || adv;
  assign pair      = adv ? k + AW'(1) : k;

  // Addresses are only meaningful alongside the read strobe; park them at zero otherwise.
  always_comb begin
    sink_addrA = '0;
    sink_addrB = '0;
    if (rd_en) begin
      sink_addrA = pair << 1;
      sink_addrB = (pair << 1) + AW'(1);
    end
  end

  // RAM output holds between reads, so the line is steered straight from the sink port.
  always_comb begin
    out_data = '0;
    case (state)
      BEAT_A:  out_data = sink_dA;
      BEAT_B:  out_data = sink_dB;
      default: out_data = '0;
    endcase
  end

  // Sequencer: claim a slot, issue pair reads, stream A then B, release the slot on FINISH.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      rd_finish <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!sink_empty) begin
            k         <= '0;
            rd_finish <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          out_valid <= 1'b1;
          state     <= BEAT_A;
        end
        BEAT_A: begin
          if (out_ready) begin
            out_last <= last_pair;
            state    <= BEAT_B;
          end
        end
        BEAT_B: begin
          if (out_ready) begin
            out_last <= 1'b0;
            if (last_pair) begin
              out_valid <= 1'b0;
              rd_finish <= 1'b1;
              state     <= FINISH;
            end else begin
              k     <= k + AW'(1);
              state <= BEAT_A;
            end
          end
        end
        FINISH: begin
          k     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POLY_FIFO_READER_PERF_EN
  // Saturating activity counters: completed polynomials and backpressured cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      poly_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == FINISH && poly_cnt != 16'hFFFF)
        poly_cnt <= poly_cnt + 16'd1;
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_poly_fifo_reader.sv
// tb/tb_poly_fifo_reader.sv - directed bench for poly_fifo_reader with a small FIFO/RAM model
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 3
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 2
`endif

module tb_poly_fifo_reader;

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `BIT_WIDTH*`LINE_SIZE;
  localparam int NL = 2**AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sink_empty;
  logic [DW-1:0] sink_dA = '0;
  logic [DW-1:0] sink_dB = '0;
  logic [AW-1:0] sink_addrA, sink_addrB;
  logic          rd_finish, rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
`ifdef POLY_FIFO_READER_PERF_EN
  logic [15:0]   poly_cnt;
  logic [31:0]   stall_cnt;
`endif

  poly_fifo_reader dut (
    .clk(clk), .rstn(rstn), .sink_empty(sink_empty),
    .sink_dA(sink_dA), .sink_dB(sink_dB),
    .sink_addrA(sink_addrA), .sink_addrB(sink_addrB),
    .rd_finish(rd_finish), .rd_en(rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef POLY_FIFO_READER_PERF_EN
    , .poly_cnt(poly_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: 4 slots, read pointer advances on the edge that ends the rd_finish rise.
  logic [DW-1:0] mem [4][NL];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic          rf_q = 1'b1;

  assign sink_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (!rstn) begin
      rd_cnt <= 0;
      rf_q   <= 1'b1;
    end else begin
      rf_q <= rd_finish;
      if (rd_finish && !rf_q) rd_cnt <= rd_cnt + 1;
    end
    if (rd_en) begin
      sink_dA <= mem[rd_cnt % 4][sink_addrA];
      sink_dB <= mem[rd_cnt % 4][sink_addrB];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_poly(input int tag);
    for (int i = 0; i < NL; i++) mem[wr_cnt % 4][i] = DW'(tag*256 + i);
    wr_cnt = wr_cnt + 1;
  endtask

  int            beat_cyc [32];
  int            stall_n, rdfin0_n, rdfin1_mid;
  logic [AW-1:0] rd_addr [$];

  // mode 0: always ready; 1: ready toggles 0,1 from the first valid; 2: stall the last line 5 cycles
  task automatic drain(input int n, input int tag0, input int mode);
    int            got = 0;
    int            cyc = 0;
    int            hold = 0;
    logic          pv = 1'b0, pacc = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    bit            seen = 0, ph = 0;
    int            line, tag;
    stall_n = 0; rdfin0_n = 0; rdfin1_mid = 0;
    rd_addr.delete();
    while (got < n && cyc < 400) begin
      @(negedge clk);
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid) seen = 1;
          out_ready = seen ? ph : 1'b1;
          if (seen) ph = ~ph;
        end
        default: begin
          if (out_valid && out_last && hold < 5) begin
            out_ready = 1'b0;
            hold++;
          end else out_ready = 1'b1;
        end
      endcase
      #1;
      if (pv && !pacc) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(pd));
        check("stall_last", 64'(out_last), 64'(pl));
      end
      if (rd_en) begin
        rd_addr.push_back(sink_addrA);
        check("addrB_pair", 64'(sink_addrB), 64'(sink_addrA) + 64'd1);
      end
      if (!rd_finish) rdfin0_n++;
      else if (got > 0) rdfin1_mid++;
      if (out_valid && !out_ready) begin
        stall_n++;
        check("no_rd_en_stall", 64'(rd_en), 64'd0);
      end
      if (out_valid && out_ready) begin
        line = got % NL;
        tag  = tag0 + got / NL;
        check("line_data", 64'(out_data), 64'(tag*256 + line));
        check("line_last", 64'(out_last), 64'(line == NL-1));
        beat_cyc[got] = cyc;
        got++;
      end
      pv = out_valid; pacc = out_ready; pd = out_data; pl = out_last;
      cyc++;
    end
    check("drain_done", 64'(got), 64'(n));
  endtask

  task automatic expect_finish();
    @(negedge clk); #1;
    check("fin_rd_finish", 64'(rd_finish), 64'd1);
    check("fin_valid", 64'(out_valid), 64'd0);
    check("fin_rd_en", 64'(rd_en), 64'd0);
    repeat (3) @(negedge clk);
  endtask

`ifdef POLY_FIFO_READER_PERF_EN
  logic [15:0] poly0;
  logic [31:0] stall0;
`endif

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_finish", 64'(rd_finish), 64'd1);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_addrA", 64'(sink_addrA), 64'd0);
    check("rst_addrB", 64'(sink_addrB), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
`ifdef POLY_FIFO_READER_PERF_EN
    check("rst_poly_cnt", 64'(poly_cnt), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: one polynomial at full rate
    push_poly(0);
    drain(NL, 0, 0);
    check("t1_latency", 64'(beat_cyc[0]), 64'd1);
    check("t1_span", 64'(beat_cyc[NL-1] - beat_cyc[0]), 64'(NL-1));
    check("t1_rd_en_cnt", 64'(rd_addr.size()), 64'(NL/2));
    for (int i = 0; i < rd_addr.size(); i++) check("t1_rd_addr", 64'(rd_addr[i]), 64'(2*i));
    check("t1_rdfin0", 64'(rdfin0_n), 64'(NL+1));
    expect_finish();

    // 2: alternating backpressure
`ifdef POLY_FIFO_READER_PERF_EN
    stall0 = stall_cnt;
`endif
    push_poly(1);
    drain(NL, 1, 1);
    check("t2_stalls", 64'(stall_n), 64'(NL));
    check("t2_rd_en_cnt", 64'(rd_addr.size()), 64'(NL/2));
    out_ready = 1'b1;
    expect_finish();
`ifdef POLY_FIFO_READER_PERF_EN
    check("t2_stall_cnt", 64'(stall_cnt - stall0), 64'(NL));
`endif

    // 3: two polynomials queued
`ifdef POLY_FIFO_READER_PERF_EN
    poly0 = poly_cnt;
`endif
    push_poly(2);
    push_poly(3);
    drain(2*NL, 2, 0);
    check("t3_gap", 64'(beat_cyc[NL] - beat_cyc[NL-1]), 64'd4);
    check("t3_release_cycles", 64'(rdfin1_mid), 64'd2);
    check("t3_rd_en_cnt", 64'(rd_addr.size()), 64'(NL));
    expect_finish();
`ifdef POLY_FIFO_READER_PERF_EN
    check("t3_poly_cnt", 64'(poly_cnt - poly0), 64'd2);
`endif

    // 4: empty FIFO keeps the reader parked
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      check("t4_idle", 64'({rd_finish, rd_en, out_valid}), 64'b100);
    end

    // 5: reset during BEAT_A of pair 2, then a fresh polynomial
    push_poly(4);
    drain(4, 4, 0);
    @(negedge clk); #1;
    check("t5_beatA_valid", 64'(out_valid), 64'd1);
    check("t5_beatA_data", 64'(out_data), 64'(4*256 + 4));
    rstn = 1'b0;
    wr_cnt = 0;
    @(negedge clk); #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_rd_finish", 64'(rd_finish), 64'd1);
    check("t5_rst_rd_en", 64'(rd_en), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    push_poly(5);
    drain(NL, 5, 0);
    check("t5_restart_latency", 64'(beat_cyc[0]), 64'd1);
    expect_finish();

    // 6: stall on the final line
    push_poly(6);
    drain(NL, 6, 2);
    check("t6_stalls", 64'(stall_n), 64'd5);
    check("t6_rdfin0", 64'(rdfin0_n), 64'(NL+1+5));
    expect_finish();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
